// File: rtl/wb_stage_pipelined.sv
// MEM/WB pipeline register and write-back stage: load extraction, result select,
// register-file write port, misaligned-load detection and retired-instruction counter.
module wb_stage_pipelined #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_MEM,
  input  logic             stall_WB,
  input  logic             flush_WB,
  input  logic [XLEN-1:0]  readData,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [1:0]       ResultSrc_MEM,
  input  logic             RegWrite_MEM,
  input  logic [RA_W-1:0]  rd_MEM,
  input  logic [2:0]       funct3_MEM,
  output logic [XLEN-1:0]  writeData_ID,
  output logic [RA_W-1:0]  rd_ID,
  output logic             RegWrite_ID,
  output logic             misaligned_load,
  output logic [CNT_W-1:0] retired_count
);

  localparam int BO_W = (XLEN == 64) ? 3 : 2;

  logic             r_valid;
  logic [1:0]       r_result_src;
  logic             r_regwrite;
  logic [RA_W-1:0]  r_rd;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_read_data;
  logic [XLEN-1:0]  r_alu;
  logic [XLEN-1:0]  r_pc4;
  logic [CNT_W-1:0] r_retired;

  logic [BO_W-1:0]  w_off;
  logic [5:0]       w_byte_sh;
  logic [5:0]       w_half_sh;
  logic [5:0]       w_word_sh;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_word;
  logic [XLEN-1:0]  w_load;
  logic             w_is_load;
  logic             w_misaligned;

  // Flush beats stall; the instruction leaving WB is counted on release or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_result_src <= '0;
      r_regwrite   <= 1'b0;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_read_data  <= '0;
      r_alu        <= '0;
      r_pc4        <= '0;
      r_retired    <= '0;
    end else begin
      if (r_valid && (!stall_WB || flush_WB))
        r_retired <= r_retired + CNT_W'(1);
      if (flush_WB) begin
        r_valid <= 1'b0;
      end else if (!stall_WB) begin
        r_valid      <= valid_MEM;
        r_result_src <= ResultSrc_MEM;
        r_regwrite   <= RegWrite_MEM;
        r_rd         <= rd_MEM;
        r_funct3     <= funct3_MEM;
        r_read_data  <= readData;
        r_alu        <= alu_result;
        r_pc4        <= pc_plus4;
      end
    end
  end

  assign w_off     = r_alu[BO_W-1:0];
  assign w_byte_sh = 6'(w_off) << 3;
  assign w_half_sh = 6'(w_off[BO_W-1:1]) << 4;
  // Only RV64 has a second word lane; on RV32 the word is always the whole bus.
  assign w_word_sh = (XLEN == 64) ? (6'(r_alu[2]) << 5) : 6'd0;
  assign w_byte    = 8'(r_read_data >> w_byte_sh);
  assign w_half    = 16'(r_read_data >> w_half_sh);
  assign w_word    = 32'(r_read_data >> w_word_sh);

  always_comb begin
    w_load = r_read_data;
    case (r_funct3)
      3'b000: w_load = XLEN'($signed(w_byte));
      3'b100: w_load = XLEN'(w_byte);
      3'b001: w_load = XLEN'($signed(w_half));
      3'b101: w_load = XLEN'(w_half);
      3'b010: w_load = XLEN'($signed(w_word));
      3'b110: if (XLEN == 64) w_load = XLEN'(w_word);
      default: w_load = r_read_data;
    endcase
  end

  assign w_is_load = r_valid && (r_result_src == 2'b01);

  always_comb begin
    w_misaligned = 1'b0;
    case (r_funct3)
      3'b001, 3'b101: w_misaligned = w_off[0];
      3'b010:         w_misaligned = (w_off[1:0] != 2'b00);
      3'b110:         w_misaligned = (XLEN == 64) && (w_off[1:0] != 2'b00);
      3'b011:         w_misaligned = (XLEN == 64) && (w_off != '0);
      default:        w_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    case (r_result_src)
      2'b01:   writeData_ID = w_load;
      2'b10:   writeData_ID = r_pc4;
      default: writeData_ID = r_alu;
    endcase
  end

  assign misaligned_load = w_is_load && w_misaligned;
  assign RegWrite_ID     = r_valid && r_regwrite && (r_rd != '0) && !misaligned_load;
  assign rd_ID           = r_rd;
  assign retired_count   = r_retired;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined: an RV32 instance for the main scenarios
// and an RV64 instance with a 4-bit counter for wide loads and wrap-around.
module tb_wb_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_WB, flush_WB;
  logic [1:0]  rs;
  logic        rw;
  logic [4:0]  rd;
  logic [2:0]  f3;

  logic        v32;
  logic [31:0] rdata32, alu32, pc32;
  logic [31:0] wd32;
  logic [4:0]  rd_id32;
  logic        we32, mis32;
  logic [63:0] cnt32;

  logic        v64;
  logic [63:0] rdata64, alu64, pc64;
  logic [63:0] wd64;
  logic [4:0]  rd_id64;
  logic        we64, mis64;
  logic [3:0]  cnt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_pipelined u32 (
    .clk(clk), .reset(reset), .valid_MEM(v32), .stall_WB(stall_WB), .flush_WB(flush_WB),
    .readData(rdata32), .alu_result(alu32), .pc_plus4(pc32), .ResultSrc_MEM(rs),
    .RegWrite_MEM(rw), .rd_MEM(rd), .funct3_MEM(f3), .writeData_ID(wd32), .rd_ID(rd_id32),
    .RegWrite_ID(we32), .misaligned_load(mis32), .retired_count(cnt32)
  );

  wb_stage_pipelined #(.XLEN(64), .RA_W(5), .CNT_W(4)) u64 (
    .clk(clk), .reset(reset), .valid_MEM(v64), .stall_WB(stall_WB), .flush_WB(flush_WB),
    .readData(rdata64), .alu_result(alu64), .pc_plus4(pc64), .ResultSrc_MEM(rs),
    .RegWrite_MEM(rw), .rd_MEM(rd), .funct3_MEM(f3), .writeData_ID(wd64), .rd_ID(rd_id64),
    .RegWrite_ID(we64), .misaligned_load(mis64), .retired_count(cnt64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set32(input logic v, input logic [1:0] s, input logic w, input logic [4:0] d,
                       input logic [2:0] f, input logic [31:0] rdat, input logic [31:0] a,
                       input logic [31:0] p);
    v32 = v; rs = s; rw = w; rd = d; f3 = f; rdata32 = rdat; alu32 = a; pc32 = p;
  endtask

  task automatic set64(input logic v, input logic [1:0] s, input logic w, input logic [4:0] d,
                       input logic [2:0] f, input logic [63:0] rdat, input logic [63:0] a);
    v64 = v; rs = s; rw = w; rd = d; f3 = f; rdata64 = rdat; alu64 = a; pc64 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_WB = 1'b0; flush_WB = 1'b0; v64 = 1'b0;
    rdata64 = '0; alu64 = '0; pc64 = '0;
    set32(1'b0, 2'b00, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    #1;
    checks++; if ({wd32, rd_id32, we32, mis32} !== 39'h0) begin errors++;
      $display("FAIL reset_outputs: got wd=%h rd=%0d we=%b mis=%b expected all 0", wd32, rd_id32, we32, mis32); end
    checks++; if (cnt32 !== 64'd0) begin errors++;
      $display("FAIL reset_count: got %0d expected 0", cnt32); end
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (cnt32 !== 64'd0 || we32 !== 1'b0 || wd32 !== 32'h0) begin errors++;
      $display("FAIL idle_10: got cnt=%0d we=%b wd=%h expected 0/0/0", cnt32, we32, wd32); end
  endtask

  task automatic test_load_byte();
    set32(1'b1, 2'b01, 1'b1, 5'd5, 3'b000, 32'h80FF7F01, 32'h00001003, 32'h0);
    tick();
    checks++; if (wd32 !== 32'hFFFFFF80 || we32 !== 1'b1 || rd_id32 !== 5'd5) begin errors++;
      $display("FAIL lb: got wd=%h we=%b rd=%0d expected ffffff80/1/5", wd32, we32, rd_id32); end
    checks++; if (cnt32 !== 64'd0) begin errors++;
      $display("FAIL lb_count: got %0d expected 0", cnt32); end
    set32(1'b1, 2'b01, 1'b1, 5'd5, 3'b100, 32'h80FF7F01, 32'h00001003, 32'h0);
    tick();
    checks++; if (wd32 !== 32'h00000080 || we32 !== 1'b1) begin errors++;
      $display("FAIL lbu: got wd=%h we=%b expected 00000080/1", wd32, we32); end
    checks++; if (cnt32 !== 64'd1) begin errors++;
      $display("FAIL lbu_count: got %0d expected 1", cnt32); end
    v32 = 1'b0;
    tick();
    checks++; if (cnt32 !== 64'd2 || we32 !== 1'b0) begin errors++;
      $display("FAIL load_drain: got cnt=%0d we=%b expected 2/0", cnt32, we32); end
  endtask

  task automatic test_misaligned();
    set32(1'b1, 2'b01, 1'b1, 5'd6, 3'b001, 32'h80FF7F01, 32'h00000001, 32'h0);
    tick();
    checks++; if (mis32 !== 1'b1 || we32 !== 1'b0) begin errors++;
      $display("FAIL lh_misaligned: got mis=%b we=%b expected 1/0", mis32, we32); end
    set32(1'b1, 2'b01, 1'b1, 5'd8, 3'b001, 32'h80FF7F01, 32'h00000002, 32'h0);
    tick();
    checks++; if (cnt32 !== 64'd3) begin errors++;
      $display("FAIL misaligned_count: got %0d expected 3", cnt32); end
    checks++; if (mis32 !== 1'b0 || we32 !== 1'b1 || wd32 !== 32'hFFFF80FF) begin errors++;
      $display("FAIL lh_aligned: got mis=%b we=%b wd=%h expected 0/1/ffff80ff", mis32, we32, wd32); end
    set32(1'b1, 2'b01, 1'b1, 5'd8, 3'b010, 32'h80FF7F01, 32'h00000002, 32'h0);
    tick();
    checks++; if (mis32 !== 1'b1 || we32 !== 1'b0) begin errors++;
      $display("FAIL lw_misaligned: got mis=%b we=%b expected 1/0", mis32, we32); end
    v32 = 1'b0;
    tick();
    checks++; if (cnt32 !== 64'd5 || mis32 !== 1'b0) begin errors++;
      $display("FAIL misaligned_drain: got cnt=%0d mis=%b expected 5/0", cnt32, mis32); end
  endtask

  task automatic test_jal();
    set32(1'b1, 2'b10, 1'b1, 5'd1, 3'b000, 32'h0, 32'hAAAA0000, 32'h00000104);
    tick();
    checks++; if (wd32 !== 32'h00000104 || we32 !== 1'b1 || rd_id32 !== 5'd1) begin errors++;
      $display("FAIL jal: got wd=%h we=%b rd=%0d expected 00000104/1/1", wd32, we32, rd_id32); end
    set32(1'b1, 2'b10, 1'b1, 5'd0, 3'b000, 32'h0, 32'hAAAA0000, 32'h00000104);
    tick();
    checks++; if (wd32 !== 32'h00000104 || we32 !== 1'b0 || rd_id32 !== 5'd0) begin errors++;
      $display("FAIL jal_x0: got wd=%h we=%b rd=%0d expected 00000104/0/0", wd32, we32, rd_id32); end
    set32(1'b1, 2'b11, 1'b1, 5'd2, 3'b000, 32'h0, 32'hDEADBEEF, 32'h00000104);
    tick();
    checks++; if (wd32 !== 32'hDEADBEEF || we32 !== 1'b1 || cnt32 !== 64'd7) begin errors++;
      $display("FAIL reserved_src: got wd=%h we=%b cnt=%0d expected deadbeef/1/7", wd32, we32, cnt32); end
    v32 = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    set32(1'b1, 2'b00, 1'b1, 5'd7, 3'b000, 32'h0, 32'h12345678, 32'h0);
    tick();
    set32(1'b1, 2'b00, 1'b1, 5'd9, 3'b000, 32'h0, 32'hFFFF0000, 32'h0);
    stall_WB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wd32 !== 32'h12345678 || rd_id32 !== 5'd7 || we32 !== 1'b1 || cnt32 !== 64'd8) begin errors++;
        $display("FAIL stall_hold_%0d: got wd=%h rd=%0d we=%b cnt=%0d expected 12345678/7/1/8",
                 i, wd32, rd_id32, we32, cnt32); end
    end
    stall_WB = 1'b0; v32 = 1'b0;
    tick();
    checks++; if (cnt32 !== 64'd9 || we32 !== 1'b0) begin errors++;
      $display("FAIL stall_release: got cnt=%0d we=%b expected 9/0", cnt32, we32); end
    set32(1'b1, 2'b00, 1'b1, 5'd4, 3'b000, 32'h0, 32'h00000055, 32'h0);
    tick();
    stall_WB = 1'b1; flush_WB = 1'b1;
    tick();
    checks++; if (we32 !== 1'b0 || cnt32 !== 64'd10) begin errors++;
      $display("FAIL stall_flush: got we=%b cnt=%0d expected 0/10", we32, cnt32); end
    stall_WB = 1'b0; flush_WB = 1'b0; v32 = 1'b0;
    tick();
    checks++; if (cnt32 !== 64'd10) begin errors++;
      $display("FAIL after_flush: got cnt=%0d expected 10", cnt32); end
  endtask

  task automatic test_reset_mid_stall();
    set32(1'b1, 2'b00, 1'b1, 5'd3, 3'b000, 32'h0, 32'h00000077, 32'h0);
    tick();
    stall_WB = 1'b1; v32 = 1'b0;
    tick();
    checks++; if (we32 !== 1'b1 || wd32 !== 32'h00000077 || cnt32 !== 64'd10) begin errors++;
      $display("FAIL pre_reset_stall: got we=%b wd=%h cnt=%0d expected 1/00000077/10", we32, wd32, cnt32); end
    #2 reset = 1'b1;
    #1;
    checks++; if (we32 !== 1'b0 || wd32 !== 32'h0 || rd_id32 !== 5'd0 || cnt32 !== 64'd0) begin errors++;
      $display("FAIL async_reset: got we=%b wd=%h rd=%0d cnt=%0d expected all 0", we32, wd32, rd_id32, cnt32); end
    tick();
    reset = 1'b0; stall_WB = 1'b0;
    tick();
    checks++; if (cnt32 !== 64'd0) begin errors++;
      $display("FAIL post_reset_count: got %0d expected 0", cnt32); end
  endtask

  task automatic test_rv64();
    set64(1'b1, 2'b01, 1'b1, 5'd3, 3'b010, 64'h80000001_11223344, 64'h4);
    tick();
    checks++; if (wd64 !== 64'hFFFFFFFF80000001 || we64 !== 1'b1 || mis64 !== 1'b0) begin errors++;
      $display("FAIL rv64_lw: got wd=%h we=%b mis=%b expected ffffffff80000001/1/0", wd64, we64, mis64); end
    set64(1'b1, 2'b01, 1'b1, 5'd3, 3'b110, 64'h80000001_11223344, 64'h4);
    tick();
    checks++; if (wd64 !== 64'h0000000080000001) begin errors++;
      $display("FAIL rv64_lwu: got %h expected 0000000080000001", wd64); end
    set64(1'b1, 2'b01, 1'b1, 5'd3, 3'b011, 64'h80000001_11223344, 64'h0);
    tick();
    checks++; if (wd64 !== 64'h80000001_11223344 || mis64 !== 1'b0) begin errors++;
      $display("FAIL rv64_ld: got wd=%h mis=%b expected 8000000111223344/0", wd64, mis64); end
    set64(1'b1, 2'b01, 1'b1, 5'd3, 3'b011, 64'h80000001_11223344, 64'h4);
    tick();
    checks++; if (mis64 !== 1'b1 || we64 !== 1'b0) begin errors++;
      $display("FAIL rv64_ld_misaligned: got mis=%b we=%b expected 1/0", mis64, we64); end
    set64(1'b1, 2'b01, 1'b1, 5'd3, 3'b000, 64'h80000001_11223344, 64'h7);
    tick();
    checks++; if (wd64 !== 64'hFFFFFFFFFFFFFF80 || we64 !== 1'b1) begin errors++;
      $display("FAIL rv64_lb_top: got wd=%h we=%b expected ffffffffffffff80/1", wd64, we64); end
    v64 = 1'b0;
    tick();
    checks++; if (cnt64 !== 4'd5) begin errors++;
      $display("FAIL rv64_count: got %0d expected 5", cnt64); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set64(1'b1, 2'b00, 1'b1, 5'd10, 3'b000, 64'h0, 64'(i));
      tick();
    end
    checks++; if (cnt64 !== 4'd0) begin errors++;
      $display("FAIL rv64_wrap_zero: got %0d expected 0", cnt64); end
    v64 = 1'b0;
    tick();
    checks++; if (cnt64 !== 4'd1) begin errors++;
      $display("FAIL rv64_wrap: got %0d expected 1", cnt64); end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_misaligned();
    test_jal();
    test_stall();
    test_reset_mid_stall();
    test_rv64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
